// File: rtl/conv_pkg.sv
// Shared geometry, widths and FSM encoding for the convolution layer controller.
package conv_pkg;

    localparam int IMG_W   = 8;
    localparam int K       = 3;
    localparam int OUT_W   = IMG_W - K + 1;
    localparam int COORD_W = $clog2(IMG_W);
    localparam int ADDR_W  = 2 * COORD_W;
    localparam int KIDX_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/conv_layer_controller_if.sv
// Control/status bundle between the host side (master) and the controller (slave).
interface conv_layer_controller_if;
    import conv_pkg::*;

    logic                start;
    logic                clear;
    logic                stall;
    logic [ADDR_W-1:0]   rom_addr;
    logic                load_en;
    logic                window_valid;
    logic [COORD_W-1:0]  out_row;
    logic [KIDX_W-1:0]   kernel_row;
    logic [KIDX_W-1:0]   kernel_col;
    logic                acc_clear;
    logic                row_done;
    logic                busy;
    logic                done;
    logic [1:0]          state;

    modport master (
        output start, clear, stall,
        input  rom_addr, load_en, window_valid, out_row, kernel_row, kernel_col,
               acc_clear, row_done, busy, done, state
    );

    modport slave (
        input  start, clear, stall,
        output rom_addr, load_en, window_valid, out_row, kernel_row, kernel_col,
               acc_clear, row_done, busy, done, state
    );

endinterface

// File: rtl/conv_index_counter.sv
// Nested col / kernel_col / kernel_row / out_row counters, plus the image row
// currently addressed (out_row + kernel_row) kept as its own register.
module conv_index_counter #(
    parameter int IMG_W = conv_pkg::IMG_W,
    parameter int K     = conv_pkg::K
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           load_step,
    input  logic                           win_step,
    output logic [conv_pkg::COORD_W-1:0]   col,
    output logic [conv_pkg::COORD_W-1:0]   in_row,
    output logic [conv_pkg::KIDX_W-1:0]    kernel_col,
    output logic [conv_pkg::KIDX_W-1:0]    kernel_row,
    output logic [conv_pkg::COORD_W-1:0]   out_row,
    output logic                           last_col,
    output logic                           last_kcol,
    output logic                           last_win
);
    import conv_pkg::*;

    logic last_krow;

    assign last_col  = (col == COORD_W'(IMG_W - 1));
    assign last_kcol = (kernel_col == KIDX_W'(K - 1));
    assign last_krow = (kernel_row == KIDX_W'(K - 1));
    assign last_win  = last_kcol && last_krow && (out_row == COORD_W'(IMG_W - K));

    // NOTE: sequential state uses non-blocking assignments so every counter
    // updates from the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            in_row     <= '0;
            kernel_col <= '0;
            kernel_row <= '0;
            out_row    <= '0;
        end else if (clear || (win_step && last_win)) begin
            // Returning to zero on the final window leaves DONE/IDLE ready for the next pass.
            col        <= '0;
            in_row     <= '0;
            kernel_col <= '0;
            kernel_row <= '0;
            out_row    <= '0;
        end else if (load_step) begin
            col <= last_col ? '0 : col + 1'b1;
        end else if (win_step) begin
            if (!last_kcol) begin
                kernel_col <= kernel_col + 1'b1;
            end else begin
                kernel_col <= '0;
                if (last_krow) begin
                    kernel_row <= '0;
                    out_row    <= out_row + 1'b1;
                    in_row     <= in_row - COORD_W'(K - 2);
                end else begin
                    kernel_row <= kernel_row + 1'b1;
                    in_row     <= in_row + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/conv_layer_controller.sv
// Sequences image-row loads and kernel-column windows for a KxK convolution
// over an IMG_W x IMG_W image held in a ROM.
module conv_layer_controller #(
    parameter int IMG_W = conv_pkg::IMG_W,
    parameter int K     = conv_pkg::K
) (
    input  logic                    clk,
    input  logic                    rst_n,
    conv_layer_controller_if.slave  bus
);
    import conv_pkg::*;

    state_t              state_q;
    logic [COORD_W-1:0]  col;
    logic [COORD_W-1:0]  in_row;
    logic                last_col;
    logic                last_kcol;
    logic                last_win;

    // window_valid is the one output allowed to see stall in the same cycle.
    assign bus.window_valid = (state_q == ST_COMPUTE) && !bus.stall;
    assign bus.rom_addr     = {in_row, col};
    assign bus.state        = state_q;

    conv_index_counter #(.IMG_W(IMG_W), .K(K)) u_index (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (bus.clear),
        .load_step  (state_q == ST_LOAD),
        .win_step   (bus.window_valid),
        .col        (col),
        .in_row     (in_row),
        .kernel_col (bus.kernel_col),
        .kernel_row (bus.kernel_row),
        .out_row    (bus.out_row),
        .last_col   (last_col),
        .last_kcol  (last_kcol),
        .last_win   (last_win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            bus.load_en   <= 1'b0;
            bus.acc_clear <= 1'b0;
            bus.row_done  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else if (bus.clear) begin
            state_q       <= ST_IDLE;
            bus.load_en   <= 1'b0;
            bus.acc_clear <= 1'b0;
            bus.row_done  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q     <= ST_LOAD;
                        bus.load_en <= 1'b1;
                        bus.busy    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (last_col) begin
                        state_q       <= ST_COMPUTE;
                        bus.load_en   <= 1'b0;
                        bus.acc_clear <= (bus.kernel_row == '0);
                    end
                end
                ST_COMPUTE: begin
                    // Flags describe the window being presented, so they hold through a stall.
                    if (!bus.stall) begin
                        bus.acc_clear <= 1'b0;
                        if (last_kcol) begin
                            bus.row_done <= 1'b0;
                            if (last_win) begin
                                state_q  <= ST_DONE;
                                bus.busy <= 1'b0;
                                bus.done <= 1'b1;
                            end else begin
                                state_q     <= ST_LOAD;
                                bus.load_en <= 1'b1;
                            end
                        end else begin
                            bus.row_done <= (bus.kernel_col == KIDX_W'(K - 2)) &&
                                            (bus.kernel_row == KIDX_W'(K - 1));
                        end
                    end
                end
                ST_DONE: begin
                    state_q  <= ST_IDLE;
                    bus.done <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_layer_controller.sv
// Directed bench for conv_layer_controller: full passes, stall, ignored start,
// clear and asynchronous reset, with hand-computed cycle expectations.
module tb_conv_layer_controller;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    conv_layer_controller_if bus ();

    conv_layer_controller #(.IMG_W(8), .K(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    localparam int MAX_C = 260;

    logic [31:0] addr_log [MAX_C+1];
    logic [31:0] kc_log   [MAX_C+1];
    logic [31:0] wv_log   [MAX_C+1];
    logic [31:0] ac_log   [MAX_C+1];
    logic [31:0] rd_log   [MAX_C+1];
    logic [31:0] or_log   [MAX_C+1];
    logic [31:0] ld_log   [MAX_C+1];
    int wv_cnt, rd_cnt, done_cnt, done_cyc;
    bit ok;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {11'd0, bus.rom_addr, bus.load_en, bus.window_valid, bus.out_row,
                bus.kernel_row, bus.kernel_col, bus.acc_clear, bus.row_done,
                bus.busy, bus.done, bus.state};
    endfunction

    // Called one step after an edge while idle. Cycle 1 is the cycle after the
    // edge that samples start; observations are taken mid-cycle.
    task automatic run_pass(input int stall_at, input int stall_len, input int restart_at);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wv_cnt = 0; rd_cnt = 0; done_cnt = 0; done_cyc = 0;
        for (int c = 1; c <= MAX_C; c++) begin
            bus.stall = (c >= stall_at) && (c < stall_at + stall_len);
            bus.start = (c == restart_at);
            #1;
            addr_log[c] = 32'(bus.rom_addr);
            kc_log[c]   = 32'(bus.kernel_col);
            wv_log[c]   = 32'(bus.window_valid);
            ac_log[c]   = 32'(bus.acc_clear);
            rd_log[c]   = 32'(bus.row_done);
            or_log[c]   = 32'(bus.out_row);
            ld_log[c]   = 32'(bus.load_en);
            if (bus.window_valid) wv_cnt++;
            if (bus.window_valid && bus.row_done) rd_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            @(posedge clk); #1;
        end
        bus.stall = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic wait_row(input int row, input bit need_load, output bit found);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if ((32'(bus.out_row) == row) && (!need_load || bus.load_en)) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.clear = 1'b0;
        bus.stall = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", outs(), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_release", outs(), 32'd0);

        // Unstalled pass
        run_pass(0, 0, 0);
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("p1_addr_c%0d", c), addr_log[c], 32'(c - 1));
            check($sformatf("p1_load_c%0d", c), ld_log[c], 32'd1);
        end
        for (int c = 9; c <= 11; c++) begin
            check($sformatf("p1_kcol_c%0d", c), kc_log[c], 32'(c - 9));
            check($sformatf("p1_wv_c%0d", c), wv_log[c], 32'd1);
        end
        check("p1_acc_clear_first", ac_log[9], 32'd1);
        check("p1_acc_clear_second", ac_log[10], 32'd0);
        check("p1_addr_second_row", addr_log[12], 32'd8);
        for (int c = 188; c <= 195; c++)
            check($sformatf("p1_last_addr_c%0d", c), addr_log[c], 32'(c - 132));
        check("p1_final_row_done", rd_log[198], 32'd1);
        check("p1_final_out_row", or_log[198], 32'd5);
        check("p1_windows", 32'(wv_cnt), 32'd54);
        check("p1_row_dones", 32'(rd_cnt), 32'd6);
        check("p1_done_cycle", 32'(done_cyc), 32'd199);
        check("p1_done_count", 32'(done_cnt), 32'd1);
        check("p1_busy_after", 32'(bus.busy), 32'd0);
        check("p1_state_after", 32'(bus.state), 32'd0);

        // Five stalled cycles at the first COMPUTE
        run_pass(9, 5, 0);
        for (int c = 9; c <= 13; c++) begin
            check($sformatf("p2_kcol_hold_c%0d", c), kc_log[c], 32'd0);
            check($sformatf("p2_wv_stall_c%0d", c), wv_log[c], 32'd0);
        end
        check("p2_wv_release", wv_log[14], 32'd1);
        check("p2_kcol_release", kc_log[14], 32'd0);
        check("p2_kcol_advance", kc_log[15], 32'd1);
        check("p2_windows", 32'(wv_cnt), 32'd54);
        check("p2_done_cycle", 32'(done_cyc), 32'd204);

        // start re-asserted mid-pass
        run_pass(0, 0, 50);
        check("p3_done_count", 32'(done_cnt), 32'd1);
        check("p3_done_cycle", 32'(done_cyc), 32'd199);

        // start and clear together while idle
        bus.start = 1'b1;
        bus.clear = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.clear = 1'b0;
        check("sc_state", 32'(bus.state), 32'd0);
        check("sc_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        check("sc_state_later", 32'(bus.state), 32'd0);

        // Asynchronous reset during out_row 3
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_row(3, 1'b0, ok);
        check("rst_reach_row3", 32'(ok), 32'd1);
        check("rst_busy_before", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_outs", outs(), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_waits_idle", outs(), 32'd0);
        run_pass(0, 0, 0);
        check("rst_restart_addr", addr_log[1], 32'd0);
        check("rst_restart_acc_clear", ac_log[9], 32'd1);
        check("rst_restart_wv", wv_log[9], 32'd1);
        check("rst_restart_done", 32'(done_cyc), 32'd199);

        // clear during LOAD of out_row 2
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_row(2, 1'b1, ok);
        check("clr_reach_row2_load", 32'(ok), 32'd1);
        bus.clear = 1'b1;
        @(posedge clk); #1;
        bus.clear = 1'b0;
        check("clr_outs", outs(), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.done) done_cnt++;
            @(posedge clk); #1;
        end
        check("clr_no_done", 32'(done_cnt), 32'd0);
        check("clr_still_idle", 32'(bus.state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
